fifo_share_arbiter: RTL and testbench
=====================================

// Module: fifo_share_arbiter
// PURPOSE
//  Shares one shift_register_fifo instance among NREQ producers with round-robin arbitration.
//  Drives the FIFO push/pop/data_in pins and keeps its own occupancy count, so the FIFO
//  never overflows or underflows. Stores a source tag per entry in a parallel shift
//  register and exposes a valid/ready dequeue port. Sits between producer agents and the FIFO.
// PARAMETERS
//  WIDTH   8                  data width, must equal the FIFO WIDTH
//  DEPTH   8                  FIFO depth, must equal the FIFO DEPTH
//  NREQ    4                  number of producers, >= 2
//  CNTWID  $clog2(DEPTH+1)    occupancy counter width
//  SRCWID  $clog2(NREQ)       source tag width
// PORTS
//  clk            in   1            clock, rising edge
//  rst            in   1            reset, asynchronous, active-high; also wired to FIFO rst
//  req_valid      in   NREQ         producer i has data
//  req_data       in   NREQ*WIDTH   producer i data in bits [i*WIDTH +: WIDTH]
//  req_ready      out  NREQ         one-hot-or-zero; producer i's data is accepted this cycle
//  fifo_push      out  1            to FIFO push
//  fifo_pop       out  1            to FIFO pop
//  fifo_data_in   out  WIDTH        to FIFO data_in
//  fifo_data_out  in   WIDTH        from FIFO data_out (head entry)
//  fifo_empty     in   1            from FIFO empty
//  fifo_full      in   1            from FIFO full
//  deq_valid      out  1            head entry available
//  deq_ready      in   1            consumer takes the head
//  deq_data       out  WIDTH        = fifo_data_out
//  deq_src        out  SRCWID       producer index of the head entry
//  occupancy      out  CNTWID       internal count, 0..DEPTH
//  err            out  1            sticky flag: FIFO flags disagree with internal count
// BEHAVIOUR
//  Reset (async assert, deassert synchronised by the user): count=0, rr_ptr=0, all tags=0, err=0.
//   While rst=1: req_ready=0, fifo_push=0, fifo_pop=0, deq_valid=0.
//  Pop: deq_valid = (count!=0). pop_now = deq_valid & deq_ready. fifo_pop = pop_now.
//  Push space: space = (count<DEPTH) | pop_now. Push while full is allowed only with a pop in the same cycle.
//  Arbitration (combinational): g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ...
//   and wrapping mod NREQ. Then req_ready[g] = space, and every other req_ready bit = 0.
//   fifo_push = |req_ready. fifo_data_in = req_data[g] when pushing, else 0.
//  rr_ptr: on an accepted push, rr_ptr <= (g==NREQ-1) ? 0 : g+1. Otherwise it holds.
//   A blocked grant (space=0) does not advance rr_ptr.
//  Count: count <= count + push - pop, evaluated at CNTWID. Simultaneous push and pop hold the count.
//  Tags: tag[0..DEPTH-1]; deq_src = tag[0].
//   On pop, tag[j] <= tag[j+1] and the top entry <= 0.
//   On push, the tag at index (count - pop_now) <= g. With push and pop together, the write wins at that index.
//  Latency: data pushed at edge N into an empty FIFO has deq_valid=1 and deq_data valid after edge N.
//   There is no bypass in the same cycle.
//  err <= err | (fifo_empty != (count==0)) | (fifo_full != (count==DEPTH)), sampled every cycle
//   outside reset. Only rst clears it.
//  Reset mid-operation: all contents are discarded. count, tags and rr_ptr return to 0 on assertion.
// TESTING
//  1. All NREQ=4 valid with data 8'hA0+i, deq_ready=0 -> grants 0,1,2,3,0,1,2,3 in that order;
//     after 8 pushes occupancy=8, req_ready=0, err=0.
//  2. Full at 8, req_valid[2]=1, deq_ready=1 -> push and pop in the same cycle; occupancy stays 8;
//     the new entry is last out, with deq_src=2.
//  3. Only producer 3 valid, 3 pushes -> rr_ptr wraps to 0; deq order returns deq_src=3,3,3
//     with the data in push order.
//  4. Empty, deq_ready=1, no requests -> deq_valid=0 and fifo_pop=0 for 10 cycles; occupancy=0.
//  5. Force fifo_empty=0 while occupancy=0 -> err=1 next cycle and it stays 1 until rst.
//  6. Assert rst asynchronously with occupancy=5 -> occupancy=0, deq_valid=0 and req_ready=0
//     immediately; the first grant after reset goes to producer 0.

Source files
------------

// File: rtl/fifo_share_arbiter.sv
// Round-robin front end that lets NREQ producers share one shift-register FIFO.
// Owns the occupancy count, a per-entry source tag shadow and a sticky FIFO-consistency flag.
module fifo_share_arbiter #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int NREQ   = 4,
    parameter int CNTWID = $clog2(DEPTH + 1),
    parameter int SRCWID = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    fifo_push,
    output logic                    fifo_pop,
    output logic [WIDTH-1:0]        fifo_data_in,
    input  logic [WIDTH-1:0]        fifo_data_out,
    input  logic                    fifo_empty,
    input  logic                    fifo_full,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [WIDTH-1:0]        deq_data,
    output logic [SRCWID-1:0]       deq_src,
    output logic [CNTWID-1:0]       occupancy,
    output logic                    err
);

    logic [CNTWID-1:0] count_q,  count_d;
    logic [SRCWID-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRCWID-1:0] tag_q [DEPTH];
    logic [SRCWID-1:0] tag_d [DEPTH];
    logic              err_q,    err_d;

    logic [SRCWID-1:0] grant_s;
    logic              grant_vld_s;
    logic              deq_valid_s;
    logic              pop_now_s;
    logic              space_s;
    logic              push_s;
    logic [CNTWID-1:0] wr_idx_s;

    // Round-robin search: first requester at or after rr_ptr, wrapping mod NREQ
    always_comb begin
        grant_s     = {SRCWID{1'b0}};
        grant_vld_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld_s && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant_s     = SRCWID'((int'(rr_ptr_q) + k) % NREQ);
                grant_vld_s = 1'b1;
            end else begin
                grant_s     = grant_s;
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Pop/push qualification; a full FIFO still accepts a push when it pops in the same cycle
    always_comb begin
        deq_valid_s = (count_q != {CNTWID{1'b0}}) & ~rst;
        pop_now_s   = deq_valid_s & deq_ready;
        space_s     = (count_q < CNTWID'(DEPTH)) | pop_now_s;
        push_s      = grant_vld_s & space_s & ~rst;
        wr_idx_s    = count_q - CNTWID'(pop_now_s);
    end

    // Grant fan-out and FIFO-side drive
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (push_s) begin
            req_ready[grant_s] = 1'b1;
            fifo_data_in       = req_data[int'(grant_s)*WIDTH +: WIDTH];
        end else begin
            fifo_data_in       = {WIDTH{1'b0}};
        end
    end

    // Next-state for count, pointer and the consistency flag
    always_comb begin
        count_d = count_q + CNTWID'(push_s) - CNTWID'(pop_now_s);
        if (push_s) begin
            if (grant_s == SRCWID'(NREQ - 1)) begin
                rr_ptr_d = {SRCWID{1'b0}};
            end else begin
                rr_ptr_d = grant_s + SRCWID'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        err_d = err_q
              | (fifo_empty != (count_q == {CNTWID{1'b0}}))
              | (fifo_full  != (count_q == CNTWID'(DEPTH)));
    end

    // Tag shadow tracks the FIFO shift; a push lands at the slot it will occupy after any pop
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            tag_d[j] = tag_q[j];
        end
        if (pop_now_s) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                tag_d[j] = tag_q[j+1];
            end
            tag_d[DEPTH-1] = {SRCWID{1'b0}};
        end else begin
            tag_d[DEPTH-1] = tag_d[DEPTH-1];
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (push_s && (wr_idx_s == CNTWID'(j))) begin
                tag_d[j] = grant_s;
            end else begin
                tag_d[j] = tag_d[j];
            end
        end
    end

    // State registers; reset discards all contents immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= {CNTWID{1'b0}};
            rr_ptr_q <= {SRCWID{1'b0}};
            err_q    <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                tag_q[j] <= {SRCWID{1'b0}};
            end
        end else begin
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            for (int j = 0; j < DEPTH; j++) begin
                tag_q[j] <= tag_d[j];
            end
        end
    end

    assign fifo_push = push_s;
    assign fifo_pop  = pop_now_s;
    assign deq_valid = deq_valid_s;
    assign deq_data  = fifo_data_out;
    assign deq_src   = tag_q[0];
    assign occupancy = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Directed bench for fifo_share_arbiter with a behavioural shift-register FIFO attached.
module tb_fifo_share_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_push, fifo_pop;
    logic [WIDTH-1:0]      fifo_data_in, fifo_data_out;
    logic                  fifo_empty, fifo_full;
    logic                  deq_valid, deq_ready;
    logic [WIDTH-1:0]      deq_data;
    logic [1:0]            deq_src;
    logic [3:0]            occupancy;
    logic                  err;

    logic [WIDTH-1:0]      m_mem [DEPTH];
    logic [WIDTH-1:0]      m_tmp [DEPTH];
    int                    m_cnt;
    int                    m_c;
    logic                  force_ne;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_data_in(fifo_data_in),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .deq_src(deq_src), .occupancy(occupancy), .err(err)
    );

    // Shift-register FIFO standing in for the shared instance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            for (int j = 0; j < DEPTH; j++) m_mem[j] <= 8'h00;
        end else begin
            m_tmp = m_mem;
            m_c   = m_cnt;
            if (fifo_pop && m_c > 0) begin
                for (int j = 0; j < DEPTH - 1; j++) m_tmp[j] = m_tmp[j+1];
                m_tmp[DEPTH-1] = 8'h00;
                m_c = m_c - 1;
            end
            if (fifo_push && m_c < DEPTH) begin
                m_tmp[m_c] = fifo_data_in;
                m_c = m_c + 1;
            end
            m_mem <= m_tmp;
            m_cnt <= m_c;
        end
    end

    assign fifo_data_out = m_mem[0];
    assign fifo_empty    = (m_cnt == 0) & ~force_ne;
    assign fifo_full     = (m_cnt == DEPTH);

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_pop;
        logic [7:0]  e_din;
        logic [3:0]  e_occ;
        logic        e_dv;
        logic [7:0]  e_dd;
        logic [1:0]  e_src;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] vld, logic [31:0] data, logic rdy,
                                logic [3:0] e_ready, logic e_pop, logic [7:0] e_din,
                                logic [3:0] e_occ, logic e_dv, logic [7:0] e_dd,
                                logic [1:0] e_src);
        vec_t v;
        v.vld = vld; v.data = data; v.rdy = rdy; v.e_ready = e_ready; v.e_pop = e_pop;
        v.e_din = e_din; v.e_occ = e_occ; v.e_dv = e_dv; v.e_dd = e_dd; v.e_src = e_src;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] DALL = 32'hA3A2A1A0;
    logic [7:0] drain_dd [8];
    logic [1:0] drain_src [8];

    initial begin
        // Test 1: four producers always valid, no consumer
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(4'hF, DALL, 1'b0, 4'(1 << (i % 4)), 1'b0, 8'(8'hA0 + i % 4),
                              4'(i), (i > 0), 8'hA0, 2'd0));
        vecs.push_back(mk(4'hF, DALL, 1'b0, 4'h0, 1'b0, 8'h00, 4'd8, 1'b1, 8'hA0, 2'd0));
        // Test 2: push while full with a simultaneous pop
        vecs.push_back(mk(4'b0100, DALL, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'd8, 1'b1, 8'hA0, 2'd0));
        drain_dd  = '{8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA2};
        drain_src = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(4'h0, DALL, 1'b1, 4'h0, 1'b1, 8'h00, 4'(8 - k), 1'b1,
                              drain_dd[k], drain_src[k]));
        // Test 3: only producer 3, pointer wrap, then drain in order
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(4'b1000, {8'(8'h31 + k), 24'h0}, 1'b0, 4'b1000, 1'b0,
                              8'(8'h31 + k), 4'(k), (k > 0), 8'h31, 2'd3));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(4'h0, DALL, 1'b1, 4'h0, 1'b1, 8'h00, 4'(3 - k), 1'b1,
                              8'(8'h31 + k), 2'd3));
        vecs.push_back(mk(4'hF, DALL, 1'b0, 4'b0001, 1'b0, 8'hA0, 4'd0, 1'b0, 8'h00, 2'd0));
        vecs.push_back(mk(4'h0, DALL, 1'b1, 4'h0, 1'b1, 8'h00, 4'd1, 1'b1, 8'hA0, 2'd0));
        vecs.push_back(mk(4'h0, DALL, 1'b0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 2'd0));

        // Reset state, with requests pending during reset
        rst = 1'b1; force_ne = 1'b0;
        req_valid = 4'hF; req_data = DALL; deq_ready = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_push", 32'(fifo_push), 32'h0);
        chk("rst_pop", 32'(fifo_pop), 32'h0);
        chk("rst_deq_valid", 32'(deq_valid), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 4'h0; deq_ready = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid = vecs[i].vld; req_data = vecs[i].data; deq_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_push", i), 32'(fifo_push), 32'(|vecs[i].e_ready));
            chk($sformatf("v%0d_pop", i), 32'(fifo_pop), 32'(vecs[i].e_pop));
            chk($sformatf("v%0d_din", i), 32'(fifo_data_in), 32'(vecs[i].e_din));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d_deq_data", i), 32'(deq_data), 32'(vecs[i].e_dd));
                chk($sformatf("v%0d_deq_src", i), 32'(deq_src), 32'(vecs[i].e_src));
            end
        end

        // Test 4: empty with consumer ready, nothing may pop
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 4'h0; deq_ready = 1'b1;
            #1;
            chk($sformatf("idle%0d_deq_valid", c), 32'(deq_valid), 32'h0);
            chk($sformatf("idle%0d_pop", c), 32'(fifo_pop), 32'h0);
            chk($sformatf("idle%0d_occ", c), 32'(occupancy), 32'h0);
        end

        // Test 5: FIFO empty flag disagrees with count
        @(negedge clk);
        deq_ready = 1'b0; force_ne = 1'b1;
        #1 chk("err_before_edge", 32'(err), 32'h0);
        @(posedge clk);
        #1 chk("err_set", 32'(err), 32'h1);
        @(negedge clk);
        force_ne = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", 32'(err), 32'h1);

        // Test 6: async reset with five entries held, pointer parked at 3
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b0100; req_data = DALL;
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1 chk("pre_rst_occ", 32'(occupancy), 32'd5);
        #1 rst = 1'b1;
        #1;
        chk("async_occ", 32'(occupancy), 32'h0);
        chk("async_deq_valid", 32'(deq_valid), 32'h0);
        chk("async_req_ready", 32'(req_ready), 32'h0);
        chk("async_push", 32'(fifo_push), 32'h0);
        chk("async_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        chk("post_rst_din", 32'(fifo_data_in), 32'hA0);
        @(posedge clk);
        #1;
        chk("post_rst_occ", 32'(occupancy), 32'd1);
        chk("post_rst_src", 32'(deq_src), 32'd0);
        chk("post_rst_data", 32'(deq_data), 32'hA0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
